// File: rtl/mvm_output_stage.sv
// Output stage of the matrix-vector engine: converts each accepted group of P
// accumulator lanes (optional ReLU, then saturation) and streams them out one per cycle.
module mvm_output_stage #(
  parameter int P     = 1,
  parameter int M     = 13,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int DEPTH = 16,
  parameter int RELU  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [P*IN_W-1:0]          in_data,
  output logic                       done,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             last;
    logic [OUT_W-1:0] data;
  } entry_t;

  // ReLU first, then clamp to the signed OUT_W range: a value fits exactly when
  // all bits from the OUT_W sign bit upward agree.
  function automatic logic [OUT_W-1:0] convert(input logic [IN_W-1:0] v);
    logic [IN_W-1:0]      x;
    logic [IN_W-OUT_W:0]  upper;
    logic [OUT_W-1:0]     sat_max;
    logic [OUT_W-1:0]     sat_min;
    x = v;
    if (RELU != 0 && v[IN_W-1]) x = '0;
    upper   = x[IN_W-1:OUT_W-1];
    sat_max = '1;
    sat_max[OUT_W-1] = 1'b0;
    sat_min = '0;
    sat_min[OUT_W-1] = 1'b1;
    if (&upper || ~|upper) return x[OUT_W-1:0];
    else if (x[IN_W-1])    return sat_min;
    else                   return sat_max;
  endfunction

  entry_t           mem [2**PTR_W];
  entry_t           lane_entry [P];
  logic [P-1:0]     lane_we;
  logic [CNT_W-1:0] n_wr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ROW_W-1:0] wr_row;
  logic [ROW_W-1:0] row_next;
  logic             accept;
  logic             pop;
  entry_t           head;

  assign in_ready  = reset && ((DEPTH - int'(count)) >= P);
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign out_data  = head.data;
  assign out_last  = out_valid && head.last;

  // Lanes past row M-1 are dropped, so written lanes are always a contiguous
  // prefix starting at lane 0 and land at consecutive FIFO slots.
  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    lane_we = '0;
    n_wr    = '0;
    for (int k = 0; k < P; k++) begin
      lane_entry[k].data = convert(in_data[k*IN_W +: IN_W]);
      lane_entry[k].last = ((int'(wr_row) + k) == (M - 1));
      if (accept && ((int'(wr_row) + k) <= (M - 1))) begin
        lane_we[k] = 1'b1;
        n_wr       = n_wr + CNT_W'(1);
      end
    end
  end

  always_comb begin
    row_next = wr_row + ROW_W'(n_wr);
    if ((int'(wr_row) + int'(n_wr)) >= M) row_next = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_row <= '0;
      done   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_wr);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + n_wr - CNT_W'(pop);
      wr_row <= row_next;
      done   <= accept;
    end
  end

  // NOTE: storage is deliberately not reset; count gates out_valid/out_last, so stale entries are never observed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < P; k++) begin
      if (lane_we[k]) mem[wr_ptr + PTR_W'(k)] <= lane_entry[k];
    end
  end

endmodule

// File: tb/tb_mvm_output_stage.sv
// Scoreboard bench for mvm_output_stage: two single-lane instances (ReLU off/on)
// and two 4-lane instances (M=6 and M=8, DEPTH=8).
module tb_mvm_output_stage;

  localparam int LM  = 3;
  localparam int GM0 = 6;
  localparam int GM1 = 8;

  logic clk;
  logic reset;

  logic        l_valid;
  logic        l_oready;
  logic [31:0] l_data;
  logic        l_iready [2];
  logic        l_done   [2];
  logic        l_ovalid [2];
  logic        l_olast  [2];
  logic [15:0] l_odata  [2];
  logic [4:0]  l_count  [2];

  logic         g_valid  [2];
  logic         g_oready [2];
  logic [127:0] g_data   [2];
  logic         g_iready [2];
  logic         g_done   [2];
  logic         g_ovalid [2];
  logic         g_olast  [2];
  logic [15:0]  g_odata  [2];
  logic [3:0]   g_count  [2];

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        last;
  } lexp_t;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } gexp_t;

  lexp_t q_l[$];
  gexp_t q_g[$];
  int    l_row;
  bit    l_prev;
  int    g_row  [2];
  bit    g_prev [2];
  int    checks;
  int    errors;

  mvm_output_stage #(.P(1), .M(LM), .IN_W(32), .OUT_W(16), .DEPTH(16), .RELU(0)) u_lane_plain (
    .clk(clk), .reset(reset), .in_valid(l_valid), .in_ready(l_iready[0]), .in_data(l_data),
    .done(l_done[0]), .out_data(l_odata[0]), .out_valid(l_ovalid[0]), .out_ready(l_oready),
    .out_last(l_olast[0]), .count(l_count[0]));

  mvm_output_stage #(.P(1), .M(LM), .IN_W(32), .OUT_W(16), .DEPTH(16), .RELU(1)) u_lane_relu (
    .clk(clk), .reset(reset), .in_valid(l_valid), .in_ready(l_iready[1]), .in_data(l_data),
    .done(l_done[1]), .out_data(l_odata[1]), .out_valid(l_ovalid[1]), .out_ready(l_oready),
    .out_last(l_olast[1]), .count(l_count[1]));

  mvm_output_stage #(.P(4), .M(GM0), .IN_W(32), .OUT_W(16), .DEPTH(8), .RELU(0)) u_grp_m6 (
    .clk(clk), .reset(reset), .in_valid(g_valid[0]), .in_ready(g_iready[0]), .in_data(g_data[0]),
    .done(g_done[0]), .out_data(g_odata[0]), .out_valid(g_ovalid[0]), .out_ready(g_oready[0]),
    .out_last(g_olast[0]), .count(g_count[0]));

  mvm_output_stage #(.P(4), .M(GM1), .IN_W(32), .OUT_W(16), .DEPTH(8), .RELU(0)) u_grp_m8 (
    .clk(clk), .reset(reset), .in_valid(g_valid[1]), .in_ready(g_iready[1]), .in_data(g_data[1]),
    .done(g_done[1]), .out_data(g_odata[1]), .out_valid(g_ovalid[1]), .out_ready(g_oready[1]),
    .out_last(g_olast[1]), .count(g_count[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_conv(input longint v, input bit relu);
    longint x;
    x = v;
    if (relu && x < 0) x = 0;
    if (x > 32767) x = 32767;
    else if (x < -32768) x = -32768;
    return 16'(x);
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic clear_models();
    q_l.delete();
    q_g.delete();
    l_row  = 0;
    l_prev = 0;
    for (int i = 0; i < 2; i++) begin
      g_row[i]  = 0;
      g_prev[i] = 0;
    end
  endtask

  // One cycle on the single-lane pair: compare the state left by the last edge
  // against the scoreboard, then present the inputs for the next edge.
  task automatic cyc_l(input bit v, input logic [31:0] d, input bit rdy);
    int          n;
    bit          exp_ready;
    logic [15:0] ed;
    lexp_t       e;
    @(negedge clk);
    n = q_l.size();
    exp_ready = (16 - n) >= 1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (l_count[i] !== 5'(n)) begin
        errors++;
        $display("FAIL lane%0d count: got %0d expected %0d", i, l_count[i], n);
      end
      checks++;
      if (l_iready[i] !== exp_ready) begin
        errors++;
        $display("FAIL lane%0d in_ready: got %b expected %b", i, l_iready[i], exp_ready);
      end
      checks++;
      if (l_ovalid[i] !== (n != 0)) begin
        errors++;
        $display("FAIL lane%0d out_valid: got %b expected %b", i, l_ovalid[i], n != 0);
      end
      checks++;
      if (l_done[i] !== l_prev) begin
        errors++;
        $display("FAIL lane%0d done: got %b expected %b", i, l_done[i], l_prev);
      end
      if (n != 0) begin
        ed = (i == 0) ? q_l[0].d0 : q_l[0].d1;
        checks++;
        if (l_odata[i] !== ed) begin
          errors++;
          $display("FAIL lane%0d out_data: got %0h expected %0h", i, l_odata[i], ed);
        end
        checks++;
        if (l_olast[i] !== q_l[0].last) begin
          errors++;
          $display("FAIL lane%0d out_last: got %b expected %b", i, l_olast[i], q_l[0].last);
        end
      end
    end
    l_valid  = v;
    l_data   = d;
    l_oready = rdy;
    if (n != 0 && rdy) void'(q_l.pop_front());
    l_prev = v && exp_ready;
    if (l_prev) begin
      e.d0   = model_conv(longint'($signed(d)), 1'b0);
      e.d1   = model_conv(longint'($signed(d)), 1'b1);
      e.last = (l_row == LM - 1);
      q_l.push_back(e);
      l_row = (l_row == LM - 1) ? 0 : l_row + 1;
    end
  endtask

  task automatic cyc_g(input int inst, input bit v, input logic [127:0] d, input bit rdy);
    int    n;
    int    wr;
    int    mrow;
    bit    exp_ready;
    bit    acc;
    gexp_t e;
    mrow = (inst == 0) ? GM0 : GM1;
    @(negedge clk);
    n = q_g.size();
    exp_ready = (8 - n) >= 4;
    checks++;
    if (g_count[inst] !== 4'(n)) begin
      errors++;
      $display("FAIL grp%0d count: got %0d expected %0d", inst, g_count[inst], n);
    end
    checks++;
    if (g_iready[inst] !== exp_ready) begin
      errors++;
      $display("FAIL grp%0d in_ready: got %b expected %b", inst, g_iready[inst], exp_ready);
    end
    checks++;
    if (g_ovalid[inst] !== (n != 0)) begin
      errors++;
      $display("FAIL grp%0d out_valid: got %b expected %b", inst, g_ovalid[inst], n != 0);
    end
    checks++;
    if (g_done[inst] !== g_prev[inst]) begin
      errors++;
      $display("FAIL grp%0d done: got %b expected %b", inst, g_done[inst], g_prev[inst]);
    end
    if (n != 0) begin
      checks++;
      if (g_odata[inst] !== q_g[0].d) begin
        errors++;
        $display("FAIL grp%0d out_data: got %0h expected %0h", inst, g_odata[inst], q_g[0].d);
      end
      checks++;
      if (g_olast[inst] !== q_g[0].last) begin
        errors++;
        $display("FAIL grp%0d out_last: got %b expected %b", inst, g_olast[inst], q_g[0].last);
      end
    end
    g_valid[inst]  = v;
    g_data[inst]   = d;
    g_oready[inst] = rdy;
    if (n != 0 && rdy) void'(q_g.pop_front());
    acc = v && exp_ready;
    g_prev[inst] = acc;
    if (acc) begin
      wr = 0;
      for (int k = 0; k < 4; k++) begin
        if (g_row[inst] + k <= mrow - 1) begin
          e.d    = model_conv(longint'($signed(d[k*32 +: 32])), 1'b0);
          e.last = (g_row[inst] + k == mrow - 1);
          q_g.push_back(e);
          wr++;
        end
      end
      g_row[inst] = (g_row[inst] + wr == mrow) ? 0 : g_row[inst] + wr;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (l_count[i] !== 5'd0 || l_ovalid[i] !== 1'b0 || l_done[i] !== 1'b0 ||
          l_olast[i] !== 1'b0 || l_iready[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset lane%0d: got count=%0d valid=%b done=%b last=%b in_ready=%b expected all 0",
                 i, l_count[i], l_ovalid[i], l_done[i], l_olast[i], l_iready[i]);
      end
      checks++;
      if (g_count[i] !== 4'd0 || g_ovalid[i] !== 1'b0 || g_done[i] !== 1'b0 ||
          g_olast[i] !== 1'b0 || g_iready[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset grp%0d: got count=%0d valid=%b done=%b last=%b in_ready=%b expected all 0",
                 i, g_count[i], g_ovalid[i], g_done[i], g_olast[i], g_iready[i]);
      end
    end
    repeat (2) @(negedge clk);
    clear_models();
    reset = 1'b1;
  endtask

  task automatic test_single_lane();
    cyc_l(1'b1, 32'd5, 1'b1);
    cyc_l(1'b1, -32'sd7, 1'b1);
    cyc_l(1'b1, 32'd40000, 1'b1);
    repeat (4) cyc_l(1'b0, 32'd0, 1'b1);
    checks++;
    if (q_l.size() != 0) begin
      errors++;
      $display("FAIL single_lane drain: got %0d outstanding expected 0", q_l.size());
    end
  endtask

  task automatic test_relu_sat();
    int s [8] = '{-100000, 32767, 32768, -32768, -32769, 0, -1, 65535};
    for (int i = 0; i < 8; i++) cyc_l(1'b1, 32'(s[i]), (i % 3) != 1);
    repeat (12) cyc_l(1'b0, 32'd0, 1'b1);
    checks++;
    if (q_l.size() != 0) begin
      errors++;
      $display("FAIL relu_sat drain: got %0d outstanding expected 0", q_l.size());
    end
  endtask

  task automatic test_lane_order();
    cyc_g(0, 1'b1, pack4(0, 1, 2, 3), 1'b0);
    cyc_g(0, 1'b1, pack4(4, 5, 6, 7), 1'b0);
    cyc_g(0, 1'b0, '0, 1'b0);
    checks++;
    if (g_count[0] !== 4'd6) begin
      errors++;
      $display("FAIL lane_order peak count: got %0d expected 6", g_count[0]);
    end
    checks++;
    if (g_iready[0] !== 1'b0) begin
      errors++;
      $display("FAIL lane_order in_ready at 6: got %b expected 0", g_iready[0]);
    end
    repeat (8) cyc_g(0, 1'b0, '0, 1'b1);
    cyc_g(0, 1'b1, pack4(10, 11, 12, 13), 1'b1);
    cyc_g(0, 1'b1, pack4(20, 21, 22, 23), 1'b1);
    repeat (8) cyc_g(0, 1'b0, '0, 1'b1);
    checks++;
    if (q_g.size() != 0) begin
      errors++;
      $display("FAIL lane_order drain: got %0d outstanding expected 0", q_g.size());
    end
  endtask

  task automatic test_backpressure();
    cyc_g(1, 1'b1, pack4(100, 101, 102, 103), 1'b0);
    cyc_g(1, 1'b1, pack4(104, 105, 106, 107), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc_g(1, 1'b1, pack4(108, 109, 110, 111), 1'b0);
      checks++;
      if (g_count[1] !== 4'd8 || g_iready[1] !== 1'b0 || g_odata[1] !== 16'd100) begin
        errors++;
        $display("FAIL backpressure hold: got count=%0d in_ready=%b data=%0d expected 8 0 100",
                 g_count[1], g_iready[1], g_odata[1]);
      end
    end
  endtask

  task automatic test_full_recovery();
    for (int i = 0; i < 5; i++) begin
      cyc_g(1, 1'b1, pack4(108, 109, 110, 111), 1'b1);
      checks++;
      if (g_iready[1] !== (i == 4)) begin
        errors++;
        $display("FAIL full_recovery in_ready step %0d: got %b expected %b", i, g_iready[1], i == 4);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit taken;
    cyc_g(1, 1'b0, '0, 1'b1);
    checks++;
    if (g_count[1] !== 4'd7) begin
      errors++;
      $display("FAIL simultaneous count: got %0d expected 7", g_count[1]);
    end
    for (int g = 0; g < 3; g++) begin
      taken = 1'b0;
      for (int t = 0; t < 10 && !taken; t++) begin
        cyc_g(1, 1'b1, pack4(200 + 4*g, 201 + 4*g, 202 + 4*g, 203 + 4*g), 1'b1);
        taken = g_prev[1];
      end
      checks++;
      if (!taken) begin
        errors++;
        $display("FAIL simultaneous group %0d accept: got none expected accept within 10 cycles", g);
      end
    end
    repeat (16) cyc_g(1, 1'b0, '0, 1'b1);
    checks++;
    if (q_g.size() != 0) begin
      errors++;
      $display("FAIL simultaneous drain: got %0d outstanding expected 0", q_g.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cyc_l(1'b1, 32'(50 + i), 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (l_count[0] !== 5'd5 || l_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre-state: got count=%0d done=%b expected 5 1", l_count[0], l_done[0]);
    end
    reset   = 1'b0;
    l_valid = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (l_count[i] !== 5'd0 || l_ovalid[i] !== 1'b0 || l_done[i] !== 1'b0 || l_olast[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid lane%0d: got count=%0d valid=%b done=%b last=%b expected all 0",
                 i, l_count[i], l_ovalid[i], l_done[i], l_olast[i]);
      end
    end
    clear_models();
    @(negedge clk);
    reset = 1'b1;
    cyc_l(1'b1, 32'd1, 1'b1);
    cyc_l(1'b1, 32'd2, 1'b1);
    cyc_l(1'b1, 32'd3, 1'b1);
    repeat (4) cyc_l(1'b0, 32'd0, 1'b1);
    checks++;
    if (q_l.size() != 0) begin
      errors++;
      $display("FAIL reset_mid drain: got %0d outstanding expected 0", q_l.size());
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    l_valid  = 1'b0;
    l_oready = 1'b0;
    l_data   = '0;
    for (int i = 0; i < 2; i++) begin
      g_valid[i]  = 1'b0;
      g_oready[i] = 1'b0;
      g_data[i]   = '0;
    end
    clear_models();
    test_reset();
    test_single_lane();
    test_relu_sat();
    test_lane_order();
    test_backpressure();
    test_full_recovery();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
